// File: rtl/ysyx_22040237_mdu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the RV64M multiply/divide unit.
package ysyx_22040237_mdu_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned WLEN = 32;

   localparam logic [2:0] Funct3Mul    = 3'b000;
   localparam logic [2:0] Funct3Mulh   = 3'b001;
   localparam logic [2:0] Funct3Mulhsu = 3'b010;
   localparam logic [2:0] Funct3Mulhu  = 3'b011;
   localparam logic [2:0] Funct3Div    = 3'b100;
   localparam logic [2:0] Funct3Divu   = 3'b101;
   localparam logic [2:0] Funct3Rem    = 3'b110;
   localparam logic [2:0] Funct3Remu   = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] w);
      return {{(XLEN-WLEN){w[WLEN-1]}}, w};
   endfunction

endpackage

// File: rtl/ysyx_22040237_mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface ysyx_22040237_mdu_if;

   logic                                  in_valid_i;
   logic                                  in_ready_o;
   logic [3:0]                            op_i;
   logic [ysyx_22040237_mdu_pkg::XLEN-1:0] rs1_data_i;
   logic [ysyx_22040237_mdu_pkg::XLEN-1:0] rs2_data_i;
   logic [4:0]                            rd_idx_i;
   logic                                  flush_i;
   logic                                  out_valid_o;
   logic                                  out_ready_i;
   logic [4:0]                            rd_wr_idx_o;
   logic [ysyx_22040237_mdu_pkg::XLEN-1:0] rd_wr_data_o;
   logic                                  busy_o;

   modport master (
      output in_valid_i, op_i, rs1_data_i, rs2_data_i, rd_idx_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, rd_wr_idx_o, rd_wr_data_o, busy_o
   );

   modport slave (
      input  in_valid_i, op_i, rs1_data_i, rs2_data_i, rd_idx_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, rd_wr_idx_o, rd_wr_data_o, busy_o
   );

endinterface

// File: rtl/ysyx_22040237_mdu_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle (32 for word ops).
module ysyx_22040237_mdu_div
   import ysyx_22040237_mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic            word,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quot,
   output logic [XLEN-1:0] rem,
   output logic            done
);

   logic            active_q, active_d;
   logic            word_q, word_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] quot_q, quot_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN:0]   shifted, diff;
   logic            fits;

   // quot/rem present the values after this cycle's step so the caller can capture on done.
   always_comb begin
      shifted  = {rem_q, quot_q[XLEN-1]};
      diff     = shifted - {1'b0, dvs_q};
      fits     = ~diff[XLEN];
      quot     = {quot_q[XLEN-2:0], fits};
      rem      = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      done     = active_q & (cnt_q == (word_q ? 6'd31 : 6'd63));
      active_d = active_q;
      word_d   = word_q;
      cnt_d    = cnt_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      if (kill) begin
         active_d = 1'b0;
      end else if (start) begin
         active_d = 1'b1;
         word_d   = word;
         cnt_d    = '0;
         quot_d   = word ? {dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend;
         rem_d    = '0;
         dvs_d    = divisor;
      end else if (active_q) begin
         quot_d = quot;
         rem_d  = rem;
         cnt_d  = cnt_q + 6'd1;
         if (done) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         word_q   <= 1'b0;
         cnt_q    <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
      end else begin
         active_q <= active_d;
         word_q   <= word_d;
         cnt_q    <= cnt_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
      end
   end

endmodule

// File: rtl/ysyx_22040237_mdu.sv
// Iterative RV64M multiply/divide unit: FSM, shift-add multiplier, sign fix-up, divide specials.
// Define YSYX_22040237_MDU_EARLY_OUT_EN to end multiplies once the remaining multiplier is zero.
module ysyx_22040237_mdu
   import ysyx_22040237_mdu_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   ysyx_22040237_mdu_if.slave  bus
);

   state_e              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [4:0]          idx_q, idx_d;
   logic [XLEN-1:0]     data_q, data_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic                res_neg_q, res_neg_d;
   logic                rem_neg_q, rem_neg_d;

   logic [2:0]          f3;
   logic                word, is_div, div_sgn, sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag;
   logic                div_zero, div_ovf, accept, div_start;
   logic [XLEN-1:0]     special_raw, special_res;

   logic [2*XLEN-1:0]   prod_n, prod_fix;
   logic [XLEN-1:0]     mplier_n, mul_raw;
   logic [5:0]          iter_last;
   logic                mul_last, calc_last;
   logic [XLEN-1:0]     div_quot, div_rem, q_fix, r_fix, calc_raw, calc_res;
   logic                div_done;

   // Operand decode: W ops only sign-extend for signed divides; MULHU/MUL and MULW stay unsigned.
   always_comb begin
      f3       = bus.op_i[2:0];
      word     = bus.op_i[3];
      is_div   = f3[2];
      div_sgn  = is_div & ~f3[0];
      sgn_a    = div_sgn | (~is_div & ~word & ((f3 == Funct3Mulh) | (f3 == Funct3Mulhsu)));
      sgn_b    = div_sgn | (~is_div & ~word & (f3 == Funct3Mulh));
      a_ext    = word ? (div_sgn ? sext_word(bus.rs1_data_i[WLEN-1:0])
                                 : {{(XLEN-WLEN){1'b0}}, bus.rs1_data_i[WLEN-1:0]})
                      : bus.rs1_data_i;
      b_ext    = word ? (div_sgn ? sext_word(bus.rs2_data_i[WLEN-1:0])
                                 : {{(XLEN-WLEN){1'b0}}, bus.rs2_data_i[WLEN-1:0]})
                      : bus.rs2_data_i;
      a_neg    = sgn_a & a_ext[XLEN-1];
      b_neg    = sgn_b & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = is_div & (b_ext == '0);
      div_ovf  = div_sgn & (b_ext == '1)
               & (a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      if (div_zero) special_raw = f3[1] ? a_ext : '1;
      else          special_raw = f3[1] ? '0 : a_ext;
      special_res = word ? sext_word(special_raw[WLEN-1:0]) : special_raw;
   end

   always_comb begin
      prod_n    = prod_q + (mplier_q[0] ? mcand_q : '0);
      mplier_n  = mplier_q >> 1;
      iter_last = op_q[3] ? 6'd31 : 6'd63;
`ifdef YSYX_22040237_MDU_EARLY_OUT_EN
      mul_last  = (cnt_q == iter_last) | (mplier_n == '0);
`else
      mul_last  = cnt_q == iter_last;
`endif
      prod_fix  = res_neg_q ? -prod_n : prod_n;
      mul_raw   = ((op_q[2:0] == Funct3Mul) | op_q[3]) ? prod_fix[XLEN-1:0]
                                                       : prod_fix[2*XLEN-1:XLEN];
      q_fix     = res_neg_q ? -div_quot : div_quot;
      r_fix     = rem_neg_q ? -div_rem : div_rem;
      calc_raw  = op_q[2] ? (op_q[1] ? r_fix : q_fix) : mul_raw;
      calc_res  = op_q[3] ? sext_word(calc_raw[WLEN-1:0]) : calc_raw;
      calc_last = op_q[2] ? div_done : mul_last;
   end

   assign bus.in_ready_o = (state_q == StIdle) & ~bus.flush_i;
   assign accept         = bus.in_valid_i & bus.in_ready_o;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      mplier_d  = mplier_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      div_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d      = bus.op_i;
               idx_d     = bus.rd_idx_i;
               res_neg_d = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               mcand_d   = {{XLEN{1'b0}}, a_mag};
               mplier_d  = b_mag;
               prod_d    = '0;
               cnt_d     = '0;
               if (div_zero | div_ovf) begin
                  state_d = StDone;
                  data_d  = special_res;
               end else begin
                  state_d   = StCalc;
                  div_start = is_div;
               end
            end
         end
         StCalc: begin
            if (!op_q[2]) begin
               prod_d   = prod_n;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_n;
            end
            cnt_d = cnt_q + 6'd1;
            if (calc_last) begin
               state_d = StDone;
               data_d  = calc_res;
            end
         end
         StDone: begin
            if (bus.out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (bus.flush_i) state_d = StIdle;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         mplier_q  <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         mplier_q  <= mplier_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
      end
   end

   ysyx_22040237_mdu_div u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .kill     (bus.flush_i),
      .word     (word),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quot     (div_quot),
      .rem      (div_rem),
      .done     (div_done)
   );

   assign bus.out_valid_o  = state_q == StDone;
   assign bus.busy_o       = state_q != StIdle;
   assign bus.rd_wr_idx_o  = idx_q;
   assign bus.rd_wr_data_o = data_q;

endmodule
